// File: rtl/load_store_unit_pkg.sv
// Shared core definitions: RV32I load/store fn3 encodings, the LSU state type
// and the access legality rule used by the memory stage.
package core_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Unknown fn3 codes are rejected together with misaligned halves and words.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] fn3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (fn3)
        FN3_SB:  ok = 1'b1;
        FN3_SH:  ok = ~addr_lo[0];
        FN3_SW:  ok = (addr_lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (fn3)
        FN3_LB, FN3_LBU: ok = 1'b1;
        FN3_LH, FN3_LHU: ok = ~addr_lo[0];
        FN3_LW:          ok = (addr_lo == 2'b00);
        default:         ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Handshake: mem_req is held high with stable addr/be/wdata/we until the slave
// returns mem_ack for one cycle; mem_ack is only meaningful while mem_req is high.
interface load_store_unit_if #(
  parameter int N = 32
) ();
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [3:0]   mem_be;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load fn3.
module load_align
  import core_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] rdata,
  input  logic [1:0]   addr_lo,
  input  logic [2:0]   fn3,
  output logic [N-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (fn3)
      FN3_LB:  data = {{(N-8){byte_sel[7]}}, byte_sel};
      FN3_LBU: data = {{(N-8){1'b0}}, byte_sel};
      FN3_LH:  data = {{(N-16){half_sel[15]}}, half_sel};
      FN3_LHU: data = {{(N-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a load/store from execute into one req/ack
// transaction on the data bus, stalling the core until it completes.
module load_store_unit
  import core_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       alu_out,
  input  logic [N-1:0]       rs2_data,
  input  logic [2:0]         fn3,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               stall,
  output logic [N-1:0]       load_data,
  output logic               load_valid,
  output logic               misaligned,
  output logic               bus_err,
  load_store_unit_if.master  mem,
  output lsu_state_t         dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_t   state_q;
  logic         req_q;
  logic         we_q;
  logic [N-1:0] addr_q;
  logic [3:0]   be_q;
  logic [N-1:0] wdata_q;
  logic [1:0]   addr_lo_q;
  logic [2:0]   fn3_q;
  logic         is_load_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0] load_data_q;
  logic         load_valid_q;
  logic         bus_err_q;

  logic         access;
  logic         is_store;
  logic         legal;
  logic         start;
  logic [3:0]   be_d;
  logic [N-1:0] wdata_d;
  logic [N-1:0] aligned;

  // A simultaneous read and write is resolved as a load.
  assign access   = mem_read | mem_write;
  assign is_store = mem_write & ~mem_read;
  assign legal    = access_legal(is_store, fn3, alu_out[1:0]);
  assign start    = (state_q == IDLE) & access & legal;

  // Gated by rst_n so both stay low for the whole reset window.
  assign stall      = rst_n & (start | (state_q == REQ));
  assign misaligned = rst_n & (state_q == IDLE) & access & ~legal;

  always_comb begin
    be_d    = 4'b0000;
    wdata_d = rs2_data;
    case (fn3)
      FN3_SB: begin
        be_d    = 4'b0001 << alu_out[1:0];
        wdata_d = {4{rs2_data[7:0]}};
      end
      FN3_SH: begin
        be_d    = alu_out[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{rs2_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = rs2_data;
      end
    endcase
  end

  load_align #(.N(N)) u_load_align (
    .rdata   (mem.mem_rdata),
    .addr_lo (addr_lo_q),
    .fn3     (fn3_q),
    .data    (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      addr_lo_q    <= 2'b00;
      fn3_q        <= 3'b000;
      is_load_q    <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            we_q      <= is_store;
            addr_q    <= {alu_out[N-1:2], 2'b00};
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            addr_lo_q <= alu_out[1:0];
            fn3_q     <= fn3;
            is_load_q <= ~is_store;
            cnt_q     <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem.mem_ack) begin
            state_q      <= DONE;
            req_q        <= 1'b0;
            load_valid_q <= is_load_q;
            if (is_load_q) begin
              load_data_q <= aligned;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign bus_err     = bus_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small bus responder inside the
// access task and an expected-load queue checked on every load_valid pulse.
module tb_load_store_unit;
  import core_pkg::*;

  localparam int N       = 32;
  localparam int TIMEOUT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] alu_out = '0;
  logic [N-1:0] rs2_data = '0;
  logic [2:0]   fn3 = 3'b000;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic         stall;
  logic [N-1:0] load_data;
  logic         load_valid;
  logic         misaligned;
  logic         bus_err;
  lsu_state_t   dbg_state;

  load_store_unit_if #(.N(N)) mem_bus ();

  load_store_unit #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_out     (alu_out),
    .rs2_data    (rs2_data),
    .fn3         (fn3),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .stall       (stall),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .misaligned  (misaligned),
    .bus_err     (bus_err),
    .mem         (mem_bus.master),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-access observations
  int           r_stall, r_req, r_lv, r_err;
  logic         r_done, r_we, post_lv, post_err;
  logic [N-1:0] r_addr, r_wdata;
  logic [3:0]   r_be;
  lsu_state_t   post_state;

  // Drives one access and acts as the memory: ack in REQ cycle ack_at (0 = never).
  task automatic run_access(input logic rd, input logic wr, input logic [N-1:0] addr,
                            input logic [N-1:0] data, input logic [2:0] f3,
                            input int ack_at, input logic [N-1:0] rdata);
    r_stall = 0; r_req = 0; r_lv = 0; r_err = 0; r_done = 1'b0;
    r_we = 1'b0; r_addr = '0; r_wdata = '0; r_be = 4'b0000;
    mem_read = rd; mem_write = wr; alu_out = addr; rs2_data = data; fn3 = f3;
    mem_bus.mem_rdata = rdata;
    mem_bus.mem_ack = 1'b0;
    for (int i = 0; i < 20 && !r_done; i++) begin
      #1;
      if (mem_bus.mem_req) begin
        r_req++;
        r_addr  = mem_bus.mem_addr;
        r_be    = mem_bus.mem_be;
        r_wdata = mem_bus.mem_wdata;
        r_we    = mem_bus.mem_we;
        mem_bus.mem_ack = (r_req == ack_at);
      end else begin
        mem_bus.mem_ack = 1'b0;
      end
      if (stall) r_stall++;
      if (bus_err) r_err++;
      if (load_valid) begin
        r_lv++;
        if (exp_q.size() == 0) check("lv_unexpected", N'(exp_q.size()), N'(1));
        else check("load_data", load_data, exp_q.pop_front());
      end
      if (!stall && r_stall > 0) begin
        r_done = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_bus.mem_ack = 1'b0;
      end else begin
        @(posedge clk);
      end
    end
    if (!r_done) begin
      check("access_bound", N'(r_done), N'(1));
      mem_read = 1'b0; mem_write = 1'b0; mem_bus.mem_ack = 1'b0;
    end
    @(posedge clk);
    #1;
    post_lv = load_valid; post_err = bus_err; post_state = dbg_state;
  endtask

  // Illegal access: flagged combinationally, never requested.
  task automatic run_reject(input string tag, input logic rd, input logic wr,
                            input logic [N-1:0] addr, input logic [2:0] f3);
    mem_read = rd; mem_write = wr; alu_out = addr; fn3 = f3; rs2_data = 32'h1111_2222;
    #1;
    check({tag, "_mis"}, N'(misaligned), N'(1));
    check({tag, "_stall"}, N'(stall), N'(0));
    @(posedge clk);
    #1;
    check({tag, "_req"}, N'(mem_bus.mem_req), N'(0));
    check({tag, "_state"}, N'(dbg_state), N'(IDLE));
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check({tag, "_mis_clr"}, N'(misaligned), N'(0));
  endtask

  initial begin
    mem_bus.mem_rdata = '0;
    mem_bus.mem_ack = 1'b0;

    // Reset state, with an access presented during reset
    mem_read = 1'b1; fn3 = FN3_LW; alu_out = 32'h0000_0001;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mis", N'(misaligned), N'(0));
    alu_out = 32'h0000_0000;
    #1;
    check("rst_stall", N'(stall), N'(0));
    check("rst_req", N'(mem_bus.mem_req), N'(0));
    check("rst_we", N'(mem_bus.mem_we), N'(0));
    check("rst_be", N'(mem_bus.mem_be), N'(0));
    check("rst_addr", mem_bus.mem_addr, N'(0));
    check("rst_wdata", mem_bus.mem_wdata, N'(0));
    check("rst_ldata", load_data, N'(0));
    check("rst_lv", N'(load_valid), N'(0));
    check("rst_err", N'(bus_err), N'(0));
    check("rst_state", N'(dbg_state), N'(IDLE));
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SW, ack in second REQ cycle
    run_access(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, FN3_SW, 2, 32'h0);
    check("sw_be", N'(r_be), N'(4'b1111));
    check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check("sw_we", N'(r_we), N'(1));
    check("sw_addr", r_addr, 32'h0000_0100);
    check("sw_stall", N'(r_stall), N'(3));
    check("sw_lv", N'(r_lv), N'(0));
    check("sw_state", N'(post_state), N'(IDLE));

    // LB / LBU from the top byte lane
    exp_q.push_back(32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, FN3_LB, 1, 32'h80FF_1234);
    check("lb_addr", r_addr, 32'h0000_0100);
    check("lb_lv", N'(r_lv), N'(1));
    check("lb_lv_pulse", N'(post_lv), N'(0));
    check("lb_stall", N'(r_stall), N'(2));
    check("lb_we", N'(r_we), N'(0));
    exp_q.push_back(32'h0000_0080);
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, FN3_LBU, 1, 32'h80FF_1234);
    check("lbu_addr", r_addr, 32'h0000_0100);
    check("lbu_lv", N'(r_lv), N'(1));
    check("lbu_lv_pulse", N'(post_lv), N'(0));

    // Other lanes and half-word loads
    exp_q.push_back(32'hFFFF_FFFF);
    run_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, FN3_LB, 1, 32'h80FF_1234);
    exp_q.push_back(32'hFFFF_80FF);
    run_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, FN3_LH, 1, 32'h80FF_1234);
    exp_q.push_back(32'h0000_1234);
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, FN3_LHU, 2, 32'h80FF_1234);
    check("lhu_lv", N'(r_lv), N'(1));

    // SH / SB lane replication
    run_access(1'b0, 1'b1, 32'h0000_0102, 32'h0000_ABCD, FN3_SH, 1, 32'h0);
    check("sh_be", N'(r_be), N'(4'b1100));
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_addr", r_addr, 32'h0000_0100);
    run_access(1'b0, 1'b1, 32'h0000_0101, 32'h0000_005A, FN3_SB, 1, 32'h0);
    check("sb_be", N'(r_be), N'(4'b0010));
    check("sb_wdata", r_wdata, 32'h5A5A_5A5A);

    // Read and write together behave as a load
    exp_q.push_back(32'hCAFE_F00D);
    run_access(1'b1, 1'b1, 32'h0000_0104, 32'h0, FN3_LW, 1, 32'hCAFE_F00D);
    check("rw_we", N'(r_we), N'(0));
    check("rw_lv", N'(r_lv), N'(1));

    // Illegal accesses
    run_reject("lh_101", 1'b1, 1'b0, 32'h0000_0101, FN3_LH);
    run_reject("lw_102", 1'b1, 1'b0, 32'h0000_0102, FN3_LW);
    run_reject("ld_fn3_3", 1'b1, 1'b0, 32'h0000_0100, 3'b011);
    run_reject("st_fn3_3", 1'b0, 1'b1, 32'h0000_0100, 3'b011);
    run_reject("sw_101", 1'b0, 1'b1, 32'h0000_0101, FN3_SW);

    // Timeout with no ack
    run_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, FN3_LW, 0, 32'h5555_AAAA);
    check("to_req", N'(r_req), N'(TIMEOUT));
    check("to_err", N'(r_err), N'(1));
    check("to_err_pulse", N'(post_err), N'(0));
    check("to_lv", N'(r_lv), N'(0));
    check("to_stall", N'(r_stall), N'(TIMEOUT + 1));

    // Ack on the last allowed cycle wins over timeout
    exp_q.push_back(32'h5555_AAAA);
    run_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, FN3_LW, TIMEOUT, 32'h5555_AAAA);
    check("late_ack_err", N'(r_err), N'(0));
    check("late_ack_lv", N'(r_lv), N'(1));
    check("late_ack_req", N'(r_req), N'(TIMEOUT));

    // Reset in the middle of REQ
    mem_read = 1'b1; alu_out = 32'h0000_0010; fn3 = FN3_LW;
    #1;
    check("mid_stall", N'(stall), N'(1));
    @(posedge clk);
    #1;
    check("mid_req", N'(mem_bus.mem_req), N'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", N'(mem_bus.mem_req), N'(0));
    check("mid_rst_stall", N'(stall), N'(0));
    check("mid_rst_state", N'(dbg_state), N'(IDLE));
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h1234_5678);
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, FN3_LW, 1, 32'h1234_5678);
    check("post_rst_lv", N'(r_lv), N'(1));
    check("post_rst_addr", r_addr, 32'h0000_0010);

    check("sb_empty", N'(exp_q.size()), N'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
